// File: rtl/stuck_at_fault_locator.sv
// Observes WIN frame pairs (original vs. post-fault-insertion line) and reports
// whether the mismatches are explained by a single stuck-at bit.
//
// state  | meaning
// ACCUM  | accepting frames, folding them into the window accumulators
// EVAL   | one cycle: derive the window verdict into the report registers
// REPORT | holding valid_out until the downstream handshake
module stuck_at_fault_locator #(
    parameter int CW  = 29,
    parameter int WIN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    output logic          ready_in,
    input  logic [CW-1:0] original_line,
    input  logic [CW-1:0] infected_line,
    output logic          valid_out,
    input  logic          ready_out,
    output logic          fault_found,
    output logic [4:0]    fault_idx,
    output logic          stuck_value,
    output logic          multi_fault,
    output logic [7:0]    mismatch_count
);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        EVAL   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] mism_mask_q;
    logic [CW-1:0] and_acc_q;
    logic [CW-1:0] or_acc_q;
    logic [7:0]    frame_cnt_q;
    logic [7:0]    mcnt_acc_q;

    logic          fault_found_q;
    logic [4:0]    fault_idx_q;
    logic          stuck_value_q;
    logic          multi_fault_q;
    logic [7:0]    mismatch_count_q;

    logic          accept;
    logic          last_frame;
    logic          report_taken;
    logic [CW-1:0] diff;

    assign diff         = original_line ^ infected_line;
    assign accept       = valid_in && ready_in;
    assign last_frame   = (frame_cnt_q == 8'(WIN - 1));
    assign report_taken = valid_out && ready_out;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && last_frame) state_d = EVAL;
            EVAL:    state_d = REPORT;
            REPORT:  if (report_taken) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Output logic; ready_in is gated by rst so it reads 0 throughout reset
    always_comb begin
        ready_in  = 1'b0;
        valid_out = 1'b0;
        case (state_q)
            ACCUM:   ready_in  = rst;
            REPORT:  valid_out = 1'b1;
            default: begin
                ready_in  = 1'b0;
                valid_out = 1'b0;
            end
        endcase
    end

    // Window accumulators
    always_ff @(posedge clk) begin
        if (!rst || (state_q == REPORT && report_taken)) begin
            mism_mask_q <= '0;
            and_acc_q   <= '1;
            or_acc_q    <= '0;
            frame_cnt_q <= '0;
            mcnt_acc_q  <= '0;
        end else if (accept) begin
            mism_mask_q <= mism_mask_q | diff;
            and_acc_q   <= and_acc_q & infected_line;
            or_acc_q    <= or_acc_q | infected_line;
            frame_cnt_q <= frame_cnt_q + 8'd1;
            if (diff != '0 && mcnt_acc_q != 8'hFF) begin
                mcnt_acc_q <= mcnt_acc_q + 8'd1;
            end
        end
    end

    // Verdict: lowest mismatching bit and its stuck-at consistency
    logic [4:0] low_idx;
    logic       low_and;
    logic       low_or;
    logic       any_mism;
    logic       many_mism;
    logic       consistent;

    always_comb begin
        low_idx = 5'h1F;
        low_and = 1'b0;
        low_or  = 1'b0;
        for (int i = CW - 1; i >= 0; i--) begin
            if (mism_mask_q[i]) begin
                low_idx = 5'(i);
                low_and = and_acc_q[i];
                low_or  = or_acc_q[i];
            end
        end
    end

    assign any_mism   = (mism_mask_q != '0);
    assign many_mism  = ((mism_mask_q & (mism_mask_q - CW'(1))) != '0);
    assign consistent = low_and || !low_or;

    // Report registers: written only in EVAL, held otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            fault_found_q    <= 1'b0;
            fault_idx_q      <= 5'h1F;
            stuck_value_q    <= 1'b0;
            multi_fault_q    <= 1'b0;
            mismatch_count_q <= 8'd0;
        end else if (state_q == EVAL) begin
            fault_found_q    <= any_mism && !many_mism && consistent;
            fault_idx_q      <= low_idx;
            stuck_value_q    <= any_mism && consistent && low_and;
            multi_fault_q    <= many_mism || (any_mism && !consistent);
            mismatch_count_q <= mcnt_acc_q;
        end
    end

    assign fault_found    = fault_found_q;
    assign fault_idx      = fault_idx_q;
    assign stuck_value    = stuck_value_q;
    assign multi_fault    = multi_fault_q;
    assign mismatch_count = mismatch_count_q;

endmodule

// File: tb/tb_stuck_at_fault_locator.sv
// Directed bench for stuck_at_fault_locator: clean, single stuck-at, multi-bit,
// toggling-bit, stalled-report and mid-window-reset windows.
module tb_stuck_at_fault_locator;

    localparam int CW  = 29;
    localparam int WIN = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          ready_in;
    logic [CW-1:0] original_line;
    logic [CW-1:0] infected_line;
    logic          valid_out;
    logic          ready_out;
    logic          fault_found;
    logic [4:0]    fault_idx;
    logic          stuck_value;
    logic          multi_fault;
    logic [7:0]    mismatch_count;

    int checks   = 0;
    int failures = 0;

    stuck_at_fault_locator #(.CW(CW), .WIN(WIN)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .original_line  (original_line),
        .infected_line  (infected_line),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .fault_found    (fault_found),
        .fault_idx      (fault_idx),
        .stuck_value    (stuck_value),
        .multi_fault    (multi_fault),
        .mismatch_count (mismatch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [CW-1:0] o, input logic [CW-1:0] f);
        valid_in      = 1'b1;
        original_line = o;
        infected_line = f;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Called one cycle after the last frame edge (EVAL); ends in REPORT
    task automatic expect_report(input string tag, input logic ff, input logic [4:0] idx,
                                 input logic sv, input logic mf, input logic [7:0] cnt);
        chk({tag, "_eval_valid_out"}, 32'(valid_out), 32'd0);
        chk({tag, "_eval_ready_in"}, 32'(ready_in), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_valid_out"}, 32'(valid_out), 32'd1);
        chk({tag, "_ready_in"}, 32'(ready_in), 32'd0);
        chk({tag, "_fault_found"}, 32'(fault_found), 32'(ff));
        chk({tag, "_fault_idx"}, 32'(fault_idx), 32'(idx));
        chk({tag, "_stuck_value"}, 32'(stuck_value), 32'(sv));
        chk({tag, "_multi_fault"}, 32'(multi_fault), 32'(mf));
        chk({tag, "_mismatch_count"}, 32'(mismatch_count), 32'(cnt));
    endtask

    task automatic handshake(input string tag, input logic [4:0] idx);
        ready_out = 1'b1;
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        chk({tag, "_hs_valid_out"}, 32'(valid_out), 32'd0);
        chk({tag, "_hs_ready_in"}, 32'(ready_in), 32'd1);
        chk({tag, "_hs_idx_held"}, 32'(fault_idx), 32'(idx));
    endtask

    initial begin
        logic [CW-1:0] o;
        logic [CW-1:0] f;
        logic [CW-1:0] m;
        logic [7:0]    cnt;

        rst           = 1'b0;
        valid_in      = 1'b0;
        ready_out     = 1'b0;
        original_line = '0;
        infected_line = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_ready_in", 32'(ready_in), 32'd0);
        chk("rst_fault_found", 32'(fault_found), 32'd0);
        chk("rst_multi_fault", 32'(multi_fault), 32'd0);
        chk("rst_stuck_value", 32'(stuck_value), 32'd0);
        chk("rst_fault_idx", 32'(fault_idx), 32'h1F);
        chk("rst_mismatch_count", 32'(mismatch_count), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_release_ready_in", 32'(ready_in), 32'd1);

        // Clean window
        for (int k = 0; k < WIN; k++) frame(29'h0AAAAAAA, 29'h0AAAAAAA);
        expect_report("clean", 1'b0, 5'h1F, 1'b0, 1'b0, 8'd0);
        handshake("clean", 5'h1F);

        // Bit 5 stuck at 1, mismatching in 7 frames
        for (int k = 0; k < WIN; k++) begin
            o    = CW'($urandom);
            o[5] = (k >= 7);
            f    = o;
            f[5] = 1'b1;
            frame(o, f);
        end
        expect_report("sa1_b5", 1'b1, 5'd5, 1'b1, 1'b0, 8'd7);
        handshake("sa1_b5", 5'd5);

        // Bits 3 and 20 stuck at 0
        m   = '0;
        m[3] = 1'b1;
        m[20] = 1'b1;
        cnt = 8'd0;
        for (int k = 0; k < WIN; k++) begin
            o = CW'($urandom);
            if (k == 0) o[3] = 1'b1;
            if (k == 1) o[20] = 1'b1;
            f = o & ~m;
            if ((o & m) != '0) cnt++;
            frame(o, f);
        end
        expect_report("sa0_b3_b20", 1'b0, 5'd3, 1'b0, 1'b1, cnt);
        handshake("sa0_b3_b20", 5'd3);

        // Bit 0 inverted every frame: infected bit 0 takes both levels
        for (int k = 0; k < WIN; k++) begin
            o    = CW'($urandom);
            o[0] = k[0];
            frame(o, o ^ CW'(1));
        end
        expect_report("flip_b0", 1'b0, 5'd0, 1'b0, 1'b1, 8'd16);
        handshake("flip_b0", 5'd0);

        // Top bit stuck at 0, report stalled for 10 cycles with frames offered
        for (int k = 0; k < WIN; k++) begin
            o     = CW'($urandom);
            o[28] = (k < 3);
            f     = o;
            f[28] = 1'b0;
            frame(o, f);
        end
        expect_report("sa0_b28", 1'b1, 5'd28, 1'b0, 1'b0, 8'd3);
        valid_in      = 1'b1;
        original_line = 29'h1FFFFFFF;
        infected_line = 29'h00000000;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("stall_valid_out", 32'(valid_out), 32'd1);
            chk("stall_ready_in", 32'(ready_in), 32'd0);
            chk("stall_fault_idx", 32'(fault_idx), 32'd28);
            chk("stall_fault_found", 32'(fault_found), 32'd1);
            chk("stall_mismatch_count", 32'(mismatch_count), 32'd3);
        end
        valid_in = 1'b0;
        handshake("sa0_b28", 5'd28);

        // Stalled frames must not have been consumed: next clean window is exact
        for (int k = 0; k < WIN; k++) frame(29'h15555555, 29'h15555555);
        expect_report("post_stall", 1'b0, 5'h1F, 1'b0, 1'b0, 8'd0);
        handshake("post_stall", 5'h1F);

        // Reset after 9 faulty frames discards the partial window
        for (int k = 0; k < 9; k++) begin
            o    = CW'($urandom);
            o[7] = 1'b0;
            frame(o, o | CW'(32'h80));
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready_in", 32'(ready_in), 32'd0);
        chk("midrst_valid_out", 32'(valid_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_release_ready_in", 32'(ready_in), 32'd1);
        for (int k = 0; k < WIN; k++) begin
            chk("midrst_no_early_report", 32'(valid_out), 32'd0);
            frame(29'h0C0FFEE0, 29'h0C0FFEE0);
        end
        expect_report("midrst", 1'b0, 5'h1F, 1'b0, 1'b0, 8'd0);
        handshake("midrst", 5'h1F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
